// File: rtl/scene_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scene_pkg                                                            |
// | Field layout of the game-state words, 640x480@60 raster timing,      |
// | palette and reset snapshot values shared by the scene renderer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package scene_pkg;

  // Pipe word: [27:20] gap height, [19:10] left x, [9:0] gap top y
  localparam int PIPE_Y_LSB   = 0;
  localparam int PIPE_X_LSB   = 10;
  localparam int PIPE_GAP_LSB = 20;

  // Coin word: [31] active, [19:10] top y, [9:0] left x
  localparam int COIN_X_LSB      = 0;
  localparam int COIN_Y_LSB      = 10;
  localparam int COIN_ACTIVE_BIT = 31;

  // Bird word: [9:0] top y, [15] rising
  localparam int BIRD_Y_LSB  = 0;
  localparam int BIRD_UP_BIT = 15;

  // Horizontal timing in pixel ticks
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_TOTAL      = H_SYNC_END + H_BACK;

  // Vertical timing in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_TOTAL      = V_SYNC_END + V_BACK;

  // Palette, {r,g,b} 4 bits each
  localparam logic [11:0] C_SKY     = 12'h4CF;
  localparam logic [11:0] C_PIPE    = 12'h2A2;
  localparam logic [11:0] C_HEAD    = 12'h1D1;
  localparam logic [11:0] C_BIRD    = 12'hFD0;
  localparam logic [11:0] C_BIRD_UP = 12'hF80;
  localparam logic [11:0] C_COIN    = 12'hFF0;

  // Snapshot contents before the first frame has been latched
  localparam logic [9:0] RESET_PIPE_X = 10'd1023;
  localparam logic [9:0] RESET_BIRD_Y = 10'd240;
  localparam logic [1:0] RESET_STATUS = 2'b01;

  // Half-open span test [lo, lo+len) in 11 bits so lo+len cannot wrap
  function automatic logic in_span(input logic [10:0] pos, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scene_renderer_vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing                                                           |
// | Pixel tick divider, h/v raster counters, raw active-low syncs,       |
// | visible flag and the once-per-frame snapshot strobe.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing
  import scene_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       visible,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       snap
);

  localparam int              DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div;

  // Free-running divider; a tick is the clock where it sits at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == '0);

  // Raster position; v steps when h wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == H_TOTAL - 10'd1) begin
        h <= '0;
        v <= (v == V_TOTAL - 10'd1) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign visible = (h < H_VISIBLE) && (v < V_VISIBLE);
  assign hs_raw  = !((h >= H_SYNC_START) && (h < H_SYNC_END));
  assign vs_raw  = !((v >= V_SYNC_START) && (v < V_SYNC_END));
  assign snap    = tick && (h == 10'd0) && (v == V_VISIBLE);

endmodule
`default_nettype wire

// File: rtl/scene_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scene_renderer                                                       |
// | Latches the game-state words once per frame at the start of vblank   |
// | and draws bird, coin and pipes on a 640x480@60 VGA raster through a  |
// | counter -> hit flags -> colour pipeline.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scene_renderer
  import scene_pkg::*;
#(
  parameter int PIX_DIV   = 4,
  parameter int BIRD_X    = 40,
  parameter int BIRD_W    = 16,
  parameter int PIPE_W    = 50,
  parameter int PIPE_HEAD = 23,
  parameter int COIN_L    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  status,
  input  logic [15:0] bird_y,
  input  logic [31:0] pipe1,
  input  logic [31:0] pipe2,
  input  logic [31:0] pipe3,
  input  logic [31:0] coin,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_tick
);

  logic       tick, visible, hs_raw, vs_raw, snap;
  logic [9:0] h, v;

  vga_timing #(.PIX_DIV(PIX_DIV)) u_timing (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .h       (h),
    .v       (v),
    .visible (visible),
    .hs_raw  (hs_raw),
    .vs_raw  (vs_raw),
    .snap    (snap)
  );

  assign frame_tick = snap;

  logic [31:0] pipe_in [3];
  assign pipe_in[0] = pipe1;
  assign pipe_in[1] = pipe2;
  assign pipe_in[2] = pipe3;

  // Bits of the bus words that carry nothing for this renderer
  logic unused_bits;
  assign unused_bits = &{1'b0, bird_y[14:10], coin[30:20], pipe1[31:28], pipe2[31:28],
                         pipe3[31:28]};

  logic [1:0] snap_status;
  logic [9:0] snap_bird_y;
  logic       snap_bird_up;
  logic       snap_coin_on;
  logic [9:0] snap_cx, snap_cy;
  logic [7:0] snap_gap [3];
  logic [9:0] snap_px  [3];
  logic [9:0] snap_py  [3];

  // Frame snapshot: the raster only ever looks at these copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_status  <= RESET_STATUS;
      snap_bird_y  <= RESET_BIRD_Y;
      snap_bird_up <= 1'b0;
      snap_coin_on <= 1'b0;
      snap_cx      <= '0;
      snap_cy      <= '0;
      for (int i = 0; i < 3; i++) begin
        snap_gap[i] <= '0;
        snap_px[i]  <= RESET_PIPE_X;
        snap_py[i]  <= '0;
      end
    end else if (snap) begin
      snap_status  <= status;
      snap_bird_y  <= bird_y[BIRD_Y_LSB +: 10];
      snap_bird_up <= bird_y[BIRD_UP_BIT];
      snap_coin_on <= coin[COIN_ACTIVE_BIT];
      snap_cx      <= coin[COIN_X_LSB +: 10];
      snap_cy      <= coin[COIN_Y_LSB +: 10];
      for (int i = 0; i < 3; i++) begin
        snap_gap[i] <= pipe_in[i][PIPE_GAP_LSB +: 8];
        snap_px[i]  <= pipe_in[i][PIPE_X_LSB +: 10];
        snap_py[i]  <= pipe_in[i][PIPE_Y_LSB +: 10];
      end
    end
  end

  logic [10:0] hx, vy;
  assign hx = {1'b0, h};
  assign vy = {1'b0, v};

  // Pipe body is the column outside the gap; the head band is the part of
  // the body within PIPE_HEAD rows of the gap, above or below it.
  logic [2:0] pipe_hit, head_hit;
  for (genvar i = 0; i < 3; i++) begin : g_pipe
    logic [10:0] py, gap_end, head_top;
    assign py       = {1'b0, snap_py[i]};
    assign gap_end  = py + {3'b0, snap_gap[i]};
    assign head_top = (py >= 11'(PIPE_HEAD)) ? py - 11'(PIPE_HEAD) : 11'd0;
    assign pipe_hit[i] = in_span(hx, {1'b0, snap_px[i]}, 11'(PIPE_W)) &&
                         ((vy < py) || (vy >= gap_end));
    assign head_hit[i] = pipe_hit[i] && (vy >= head_top) &&
                         (vy < gap_end + 11'(PIPE_HEAD));
  end

  logic bird_hit, coin_hit, play;
  assign bird_hit = in_span(hx, 11'(BIRD_X), 11'(BIRD_W)) &&
                    in_span(vy, {1'b0, snap_bird_y}, 11'(BIRD_W));
  assign coin_hit = snap_coin_on && in_span(hx, {1'b0, snap_cx}, 11'(COIN_L)) &&
                    in_span(vy, {1'b0, snap_cy}, 11'(COIN_L));
  // 00 and 11 are play; 01 and 10 are setup
  assign play     = (snap_status[1] == snap_status[0]);

  logic s1_vis, s1_hs, s1_vs, s1_bird, s1_up, s1_coin, s1_head, s1_pipe;

  // Stage 1: register hit flags alongside the raw syncs; setup hides all but the bird
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vis  <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_bird <= 1'b0;
      s1_up   <= 1'b0;
      s1_coin <= 1'b0;
      s1_head <= 1'b0;
      s1_pipe <= 1'b0;
    end else if (tick) begin
      s1_vis  <= visible;
      s1_hs   <= hs_raw;
      s1_vs   <= vs_raw;
      s1_bird <= bird_hit;
      s1_up   <= snap_bird_up;
      s1_coin <= coin_hit && play;
      s1_head <= (|head_hit) && play;
      s1_pipe <= (|pipe_hit) && play;
    end
  end

  logic [11:0] pix;

  // Priority colour mux: bird, coin, head, pipe, sky; black in blanking
  always_comb begin
    pix = C_SKY;
    if (!s1_vis) begin
      pix = 12'h000;
    end else if (s1_bird) begin
      pix = s1_up ? C_BIRD_UP : C_BIRD;
    end else if (s1_coin) begin
      pix = C_COIN;
    end else if (s1_head) begin
      pix = C_HEAD;
    end else if (s1_pipe) begin
      pix = C_PIPE;
    end
  end

  logic [11:0] rgb_q;

  // Stage 2: output registers, syncs delayed to stay aligned with colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      hs    <= 1'b1;
      vs    <= 1'b1;
    end else if (tick) begin
      rgb_q <= pix;
      hs    <= s1_hs;
      vs    <= s1_vs;
    end
  end

  assign r = rgb_q[11:8];
  assign g = rgb_q[7:4];
  assign b = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_scene_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scene_renderer                                                    |
// | Drives game-state scenarios with randomised filler objects and       |
// | compares sampled pixels, syncs and frame_tick against a pixel-level  |
// | reference model of the scene.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_scene_renderer;

  localparam int P       = 2;
  localparam int H_TOT   = 800;
  localparam int V_TOT   = 525;
  localparam int FRAME   = H_TOT * V_TOT;
  localparam int SNAP_AT = 480 * H_TOT;

  localparam logic [11:0] SKY = 12'h4CF, PIPE = 12'h2A2, HEAD = 12'h1D1;
  localparam logic [11:0] BIRD = 12'hFD0, BIRD_UP = 12'hF80, COIN = 12'hFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  status;
  logic [15:0] bird_y;
  logic [31:0] pipe1, pipe2, pipe3, coin;
  logic        hs, vs, frame_tick;
  logic [3:0]  r, g, b;

  scene_renderer #(.PIX_DIV(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .status     (status),
    .bird_y     (bird_y),
    .pipe1      (pipe1),
    .pipe2      (pipe2),
    .pipe3      (pipe3),
    .coin       (coin),
    .hs         (hs),
    .vs         (vs),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_pipe(input int gap, input int x, input int y);
    logic [3:0] junk;
    junk = 4'($urandom);
    return {junk, 8'(gap), 10'(x), 10'(y)};
  endfunction

  function automatic logic [31:0] mk_coin(input bit act, input int y, input int x);
    logic [10:0] junk;
    junk = 11'($urandom);
    return {act, junk, 10'(y), 10'(x)};
  endfunction

  // Reference snapshot as the scene should currently be drawn
  logic [1:0]  m_status;
  logic [15:0] m_bird;
  logic [31:0] m_pipe [3];
  logic [31:0] m_coin;

  task automatic model_reset();
    m_status = 2'b01;
    m_bird   = 16'd240;
    m_coin   = 32'd0;
    for (int i = 0; i < 3; i++) m_pipe[i] = {12'd0, 10'd1023, 10'd0};
  endtask

  function automatic logic [11:0] ref_rgb(input int h, input int v);
    int  by, cx, cy, px, py, pg;
    bit  play, in_pipe, in_head;
    if (h >= 640 || v >= 480) return 12'h000;
    play = (m_status == 2'b00) || (m_status == 2'b11);
    by = int'(m_bird[9:0]);
    if (h >= 40 && h < 56 && v >= by && v < by + 16) return m_bird[15] ? BIRD_UP : BIRD;
    if (!play) return SKY;
    cx = int'(m_coin[9:0]);
    cy = int'(m_coin[19:10]);
    if (m_coin[31] && h >= cx && h < cx + 16 && v >= cy && v < cy + 16) return COIN;
    in_pipe = 0;
    in_head = 0;
    for (int i = 0; i < 3; i++) begin
      px = int'(m_pipe[i][19:10]);
      py = int'(m_pipe[i][9:0]);
      pg = int'(m_pipe[i][27:20]);
      if (h >= px && h < px + 50 && (v < py || v >= py + pg)) begin
        in_pipe = 1;
        if (v >= py - 23 && v < py + pg + 23) in_head = 1;
      end
    end
    if (in_head) return HEAD;
    if (in_pipe) return PIPE;
    return SKY;
  endfunction

  localparam int NT = 12;
  int tx [NT] = '{310, 110, 310, 310, 310, 310, 310, 350, 45, 205, 45, 110};
  int ty [NT] = '{100, 100, 120, 130, 200, 251, 300, 100, 145, 55, 245, 300};

  function automatic bit is_target(input int h, input int v);
    for (int i = 0; i < NT; i++) if (tx[i] == h && ty[i] == v) return 1;
    return 0;
  endfunction

  // Posedges seen since reset release
  int edges = 0;
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  int cur_c = 0, cur_h = 0, cur_v = 0, cur_fr = 0;
  int spurious = 0, ft_hits = 0, hs_low = 0, vs_lines = 0;

  // Monitor: derive raster position from clock count and compare outputs
  always @(negedge clk) begin : mon
    int n, div, q, ph, pv;
    bit exp_ft, take_rgb, take_sync;
    if (rst) begin
      check("rst_hs", hs, 1);
      check("rst_vs", vs, 1);
      check("rst_rgb", {r, g, b}, 0);
      check("rst_frame_tick", frame_tick, 0);
      model_reset();
      cur_c = 0; cur_h = 0; cur_v = 0; cur_fr = 0;
      spurious = 0; ft_hits = 0; hs_low = 0; vs_lines = 0;
    end else begin
      n      = edges;
      div    = n % P;
      cur_c  = (n + P - 1) / P;
      cur_h  = (cur_c % FRAME) % H_TOT;
      cur_v  = (cur_c % FRAME) / H_TOT;
      cur_fr = cur_c / FRAME;
      exp_ft = (div == 0) && ((cur_c % FRAME) == SNAP_AT);
      if (exp_ft) begin
        check($sformatf("frame_tick@%0d", cur_c), frame_tick, 1);
        check("spurious_frame_tick", spurious, 0);
        spurious = 0;
        ft_hits++;
        m_status = status;
        m_bird   = bird_y;
        m_pipe[0] = pipe1;
        m_pipe[1] = pipe2;
        m_pipe[2] = pipe3;
        m_coin   = coin;
      end else if (frame_tick) begin
        spurious++;
      end
      if (n >= 1 && ((n - 1) % P) == 0) begin
        q = (n - 1) / P - 1;
        if (q < 0) begin
          check("pre_pixel_hs", hs, 1);
          check("pre_pixel_vs", vs, 1);
          check("pre_pixel_rgb", {r, g, b}, 0);
        end else begin
          ph = (q % FRAME) % H_TOT;
          pv = (q % FRAME) / H_TOT;
          take_rgb  = ((q % 53) == 0) || is_target(ph, pv) || ($urandom_range(0, 199) == 0);
          take_sync = (ph >= 650 && ph <= 760 && ((pv % 64) == 0 || (pv >= 486 && pv <= 494)))
                      || ph == 400;
          if (take_rgb)
            check($sformatf("rgb(%0d,%0d)", ph, pv), {r, g, b}, ref_rgb(ph, pv));
          if (take_sync) begin
            check($sformatf("hs(%0d,%0d)", ph, pv), hs, !(ph >= 656 && ph < 752));
            check($sformatf("vs(%0d,%0d)", ph, pv), vs, !(pv >= 490 && pv < 492));
          end
          if (!hs) hs_low++;
          if (ph == 0 && !vs) vs_lines++;
          if (ph == H_TOT - 1) begin
            if ((pv % 16) == 0) check($sformatf("hs_low_ticks_line%0d", pv), hs_low, 96);
            hs_low = 0;
            if (pv == V_TOT - 1) begin
              check("vs_low_lines", vs_lines, 2);
              vs_lines = 0;
            end
          end
        end
      end
    end
  end

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    #60000000;
    errors++;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    finish_run();
  end

  initial begin
    rst    = 1'b1;
    status = 2'b10;
    bird_y = 16'd140;
    pipe1  = mk_pipe(100, 300, 150);
    pipe2  = mk_pipe(100, 30, 150);
    pipe3  = mk_pipe($urandom_range(30, 150), $urandom_range(0, 700), $urandom_range(0, 400));
    coin   = mk_coin(1'b1, 50, 200);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;

    // Frame 1 shows the setup snapshot; switch to play for frame 2
    wait (cur_fr == 1 && cur_v == 200);
    @(posedge clk);
    #2 status = 2'b11;
    pipe3 = mk_pipe($urandom_range(30, 150), $urandom_range(0, 700), $urandom_range(0, 400));

    // Mid-frame change: moved pipe, rising bird, coin off, wrapped pipe3
    wait (cur_fr == 2 && cur_v == 200);
    @(posedge clk);
    #2 status = 2'b00;
    pipe1  = mk_pipe(100, 100, 150);
    bird_y = 16'h8000 | 16'd140;
    coin   = mk_coin(1'b0, 50, 200);
    pipe3  = mk_pipe($urandom_range(30, 150), 1020, $urandom_range(0, 400));

    // Reset in the middle of frame 3
    wait (cur_fr == 3 && cur_v == 300);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;

    wait (cur_c >= SNAP_AT + 10);
    check("frame_ticks_after_reset", ft_hits, 1);
    check("spurious_frame_tick_end", spurious, 0);
    finish_run();
  end

endmodule
`default_nettype wire
